activation_packer: RTL
======================

# activation_packer

- Serial-to-parallel producer for the 256-bit packed activation bus consumed by the 16-lane adder tree.
- Accepts one signed 16-bit activation per valid/ready handshake and places accepted words into lanes 0..15 in order.
- Presents each completed vector as one 256-bit word on a valid/ready output.
- Sits between the activation buffer read port and the adder stage, and double-buffers so input streaming continues while a finished vector waits.

## Interface
- DATA_W, 16, width of one activation lane
- LANES, 16, lanes per packed vector; output width is DATA_W*LANES
- clk  input  1  rising-edge clock, single clock domain
- reset_n  input  1  asynchronous, active-low reset
- s_valid  input  1  input word valid
- s_ready  output  1  packer can accept a word this cycle
- s_data  input  DATA_W  signed activation
- s_last  input  1  end-of-stream marker; ignored unless ACT_PACKER_FLUSH_EN
- m_valid  output  1  packed vector valid
- m_ready  input  1  downstream accepts vector
- m_data  output  DATA_W*LANES  lane i at bits [(i+1)*DATA_W-1 : i*DATA_W]
- m_count  output  5  number of populated lanes, 1..16

## Operation
- Input handshake: s_valid && s_ready. Output handshake: m_valid && m_ready.
- Collect register plus lane index idx (0..15). Accepted word is written to lane idx; idx then increments.
- Lanes not yet written in the current vector read as zero. The collect register is cleared when a vector is handed off.
- States:
  - FILL: s_ready=1.
  - HOLD: s_ready=0. The collect register is complete, but the output register is still occupied.
- Completion event: accepting the word at idx=15, or accepting a word with s_last=1 when the flush feature is enabled.
- On a completion event in FILL:
  - If the output register is free this cycle (m_valid==0, or m_valid&&m_ready), the vector moves to the output register. idx is set to 0 and the state stays FILL.
  - Otherwise the state goes to HOLD, and idx and the data are retained.
- HOLD exits to FILL on the cycle the output handshake occurs. The held vector loads into the output register in that same cycle, and idx is set to 0.
- m_count: latched with the vector, equal to the number of words accepted for it.
- No arithmetic is performed. Lane data is passed bit-exact, and sign is preserved for the signed adder downstream.

## Timing
- Reset values:
  - m_valid=0, m_data=0, m_count=0
  - state=FILL, idx=0, collect register=0
  - s_ready=0 while reset_n=0, and 1 from the first cycle after release.
- Latency: m_valid rises one cycle after the completing input handshake.
- Throughput: with m_ready held high, 16 input cycles produce one output vector, with zero bubbles between vectors.
- m_data and m_count are stable while m_valid && !m_ready. m_valid is never dropped without a handshake.
- s_ready depends on state only: it is registered, with no combinational path from m_ready.
- Simultaneous output handshake and completion event in FILL: the new vector replaces the old one in the same edge, and m_valid stays 1.
- Reset asserted mid-vector or in HOLD: the partial or held vector and any pending output are discarded immediately, with no output.

## Configuration
- ACT_PACKER_FLUSH_EN defined:
  - An accepted word with s_last=1 completes the vector early; remaining lanes are zero and m_count=idx+1.
  - s_last at idx=15 behaves identically to a normal completion.
- ACT_PACKER_FLUSH_EN undefined:
  - s_last is ignored, every vector has 16 populated lanes, and m_count is constant 16 once valid.

## Structure
- Shared package tpu_pkg: DATA_W, LANES, LANE_IDX_W (=4), the packed vector width constant, and the FILL/HOLD state enum.
- One sub-module, pack_out_reg: the output register with valid/ready. It loads on a load strobe when free or draining and holds otherwise.
- The FSM, idx counter and collect register stay in activation_packer.

## Test plan
- Stream 16 words 0x0001..0x0010 with m_ready=1. Expect m_valid one cycle after the 16th handshake, lane0=0x0001, lane15=0x0010, m_count=16.
- Stream 48 words back-to-back with m_ready=1. Expect 3 vectors, s_ready never low, and m_valid in 3 single-cycle pulses 16 cycles apart.
- Hold m_ready=0 and stream 32 words. Expect the first vector held stable and s_ready low after the 32nd word (HOLD). Raise m_ready: expect the second vector to appear the next cycle and s_ready high again.
- Stream signed values 0x8000 and 0xFFFF in lanes 0/1. Expect m_data bits [31:0]=0xFFFF8000 unchanged.
- With ACT_PACKER_FLUSH_EN, send 5 words with s_last on the 5th. Expect m_count=5 and lanes 5..15 zero. Without the macro, the same stimulus produces no output until 16 words.
- Pulse reset_n low after 7 words, then send 16 words 0x00A0..0x00AF. Expect lane0=0x00A0, with no remnant of the first 7 words.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared widths, vector type and packer FSM state for the 16-lane activation datapath.
package tpu_pkg;

    localparam int DATA_W     = 16;
    localparam int LANES      = 16;
    localparam int LANE_IDX_W = 4;
    localparam int VEC_W      = DATA_W * LANES;
    localparam int COUNT_W    = 5;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

    // Lane 0 occupies the least-significant DATA_W bits of the packed vector.
    typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

endpackage

// File: rtl/activation_packer_if.sv
// Word-in / vector-out handshake bundle; master is the packer, slave is its environment.
interface activation_packer_if
    import tpu_pkg::*;
();

    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_last;
    logic                     m_valid;
    logic                     m_ready;
    logic [VEC_W-1:0]         m_data;
    logic [COUNT_W-1:0]       m_count;

    modport master (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_count
    );

    modport slave (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_count
    );

endinterface

// File: rtl/activation_packer_out_reg.sv
// pack_out_reg: single-entry valid/ready output register; load is only strobed when free or draining.
module pack_out_reg
    import tpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [VEC_W-1:0]   load_data,
    input  logic [COUNT_W-1:0] load_count,
    input  logic               m_ready,
    output logic               m_valid,
    output logic [VEC_W-1:0]   m_data,
    output logic [COUNT_W-1:0] m_count
);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            // NOTE: the data register is reset too, so m_data reads zero out of reset rather than X.
            m_data  <= '0;
            m_count <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_count <= load_count;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/activation_packer.sv
// Serial-to-parallel packer: 16 signed words -> one 256-bit vector, double-buffered.
// Optional early flush on s_last when ACT_PACKER_FLUSH_EN is defined.
module activation_packer
    import tpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    activation_packer_if.master bus
);

    pack_state_e           state;
    pack_state_e           next_state;
    logic [LANE_IDX_W-1:0] idx;
    lane_vec_t             collect;
    lane_vec_t             collect_next;
    lane_vec_t             load_data;
    logic [COUNT_W-1:0]    load_count;
    logic                  s_ready_q;
    logic                  accept;
    logic                  complete;
    logic                  out_free;
    logic                  load;

    assign bus.s_ready = s_ready_q;
    assign accept      = bus.s_valid && s_ready_q;
    assign out_free    = !bus.m_valid || bus.m_ready;

`ifdef ACT_PACKER_FLUSH_EN
    assign complete = accept && ((idx == LANE_IDX_W'(LANES - 1)) || bus.s_last);
`else
    logic unused_last;
    assign unused_last = bus.s_last;
    assign complete    = accept && (idx == LANE_IDX_W'(LANES - 1));
`endif

    // NOTE: assigning a default before the case keeps these combinational blocks latch-free.
    always_comb begin
        collect_next      = collect;
        collect_next[idx] = bus.s_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FILL;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL: if (complete && !out_free) next_state = HOLD;
            HOLD: if (bus.m_ready)           next_state = FILL;
            default:                         next_state = FILL;
        endcase
    end

    always_comb begin
        load       = 1'b0;
        load_data  = collect_next;
        load_count = {1'b0, idx} + COUNT_W'(1);
        case (state)
            FILL: load = complete && out_free;
            HOLD: begin
                load      = bus.m_ready;
                load_data = collect;
            end
            default: load = 1'b0;
        endcase
    end

    // s_ready follows the next state, so it is low in reset and never sees m_ready combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_ready_q <= 1'b0;
            idx       <= '0;
            collect   <= '0;
        end else begin
            s_ready_q <= (next_state == FILL);
            if (load) begin
                idx     <= '0;
                collect <= '0;
            end else if (state == FILL && accept) begin
                collect <= collect_next;
                if (!complete) idx <= idx + LANE_IDX_W'(1);
            end
        end
    end

    pack_out_reg u_out_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_data  (load_data),
        .load_count (load_count),
        .m_ready    (bus.m_ready),
        .m_valid    (bus.m_valid),
        .m_data     (bus.m_data),
        .m_count    (bus.m_count)
    );

endmodule
